hamming_secded_rx: RTL and testbench
====================================

# hamming_secded_rx

Serial receive-side Hamming SECDED(8,4) decoder for the Hamming system datapath. It deserialises one 8-bit codeword, computes the syndrome and overall parity, and corrects any single-bit error. It then issues a one-cycle LOAD strobe with the corrected 4-bit nibble, which drives the L/D inputs of the downstream bank of D flip-flop data registers. It also reports syndrome and error class for the error-status display stage.

## Interface
- DBL_LOAD, default 0: 1 = still pulse LOAD (with uncorrected data) on double error; 0 = suppress LOAD on double error.
- Reset CLR, asynchronous, active-high; clock CLK.
- CLK  input  1  rising-edge clock.
- CLR  input  1  asynchronous active-high reset.
- EN  input  1  global enable; low freezes every register and the FSM.
- SIN  input  1  serial codeword bit.
- SVALID  input  1  SIN qualifier, sampled on CLK rise.
- SOW  input  1  start-of-word; meaningful only with SVALID; marks codeword position 1.
- DATA  output  4  corrected nibble {d4,d3,d2,d1}; reset 4'b0000.
- LOAD  output  1  one-cycle strobe, DATA valid; reset 0.
- SYN  output  3  syndrome of last decoded word; reset 3'b000.
- ERR_COR  output  1  last word had a corrected single error (includes P0-only error); reset 0.
- ERR_DBL  output  1  last word had an uncorrectable double error; reset 0.
- BUSY  output  1  FSM not in IDLE; reset 0.
- DROP  output  1  sticky: an SVALID bit was ignored; cleared only by CLR; reset 0.

## Operation
- Codeword positions, in transmission order (position 1 first): 1=p1, 2=p2, 3=d1, 4=p4, 5=d2, 6=d3, 7=d4, 8=P0. P0 is the XOR of positions 1..7.
- Syndrome: SYN[0]=^{pos1,3,5,7}; SYN[1]=^{pos2,3,6,7}; SYN[2]=^{pos4,5,6,7}. Overall check q = XOR of positions 1..8.
- FSM states: IDLE, SHIFT, DECODE. A 3-bit position counter counts 0..7.
  - IDLE: SVALID&SOW stores SIN as position 1, sets count=1 and goes to SHIFT. SVALID without SOW is ignored and sets DROP.
  - SHIFT: SVALID&!SOW stores SIN at the position given by count and increments count. When the 8th bit is stored, the FSM goes to DECODE.
  - SHIFT, SVALID&SOW: aborts the partial word silently (no LOAD, no flag). SIN is stored as the new position 1, with count=1.
  - DECODE: lasts one enabled cycle, then returns to IDLE. Any SVALID sampled in DECODE is ignored and sets DROP.
- Decode classification:
  - SYN=0, q=0: no error. ERR_COR=0, ERR_DBL=0.
  - SYN≠0, q=1: single error at position SYN. That bit is inverted before data extraction. ERR_COR=1.
  - SYN=0, q=1: error in P0 only. Data is unchanged. ERR_COR=1.
  - SYN≠0, q=0: double error. Data is extracted uncorrected. ERR_DBL=1, ERR_COR=0.
- DATA, SYN, ERR_COR and ERR_DBL update only on the DECODE exit edge, together with LOAD.
  - On a double error with DBL_LOAD=0: SYN and ERR_DBL still update. DATA and LOAD do not; DATA holds its previous value.
- EN low:
  - No sampling of SVALID.
  - FSM, count, shift register and all outputs are held.
  - LOAD is forced to 0 while EN is low. A pending DECODE completes on the first enabled cycle.
- CLR in any state: everything returns immediately (asynchronously) to reset values, state=IDLE, count=0. A partial word is discarded.

## Timing
- Bit sampled on CLK rise when EN=1 and SVALID=1.
- The 8th bit is sampled on edge k, and the FSM is in DECODE during cycle k→k+1.
- On edge k+1: DATA, SYN and flags are registered, and LOAD rises. LOAD falls on edge k+2.
- Latency from last bit to LOAD: 1 cycle.
- BUSY is high from the edge after SOW is accepted through edge k+1.
- SVALID on edge k+1 is dropped. The earliest next SOW is accepted on edge k+2, giving a minimum word period of 9 cycles.
- No combinational path from inputs to outputs.

## Test plan
- Clean word: send bits 1,0,1,0,1,0,1,0 (DATA 4'b1011) with SOW on the first bit. Required: LOAD exactly one cycle, 1 cycle after the 8th bit; DATA=4'b1011; SYN=0; ERR_COR=0; ERR_DBL=0.
- Single error: same word with position 5 flipped. Required: SYN=3'd5, ERR_COR=1, DATA=4'b1011, LOAD pulses.
  - Repeat for every position 1..7: DATA=4'b1011 and SYN equals the flipped position each time.
  - Flip position 8: SYN=0, ERR_COR=1, DATA=4'b1011.
- Double error: flip positions 3 and 6. With DBL_LOAD=0: SYN=3'd5, ERR_DBL=1, ERR_COR=0, no LOAD, DATA holds its prior value. With DBL_LOAD=1: LOAD pulses with uncorrected DATA.
- Framing:
  - SOW reasserted after 4 bits, then a full clean word: only one LOAD, carrying the second word.
  - SVALID in IDLE without SOW: DROP=1.
  - Back-to-back SOW on edge k+1: DROP=1. SOW on edge k+2: accepted.
- EN low: drop EN for 3 cycles mid-word and during DECODE. Required: bits are not sampled, the word completes correctly once EN returns, and LOAD appears only when EN=1.
- Reset: assert CLR after 5 bits. Required: all outputs are 0 immediately; the next clean word decodes correctly.

Source files
------------

// File: rtl/hamming_secded_rx.sv
// Serial SECDED(8,4) receive decoder: deserialises one codeword,
// corrects single errors and strobes LOAD with the nibble.
module hamming_secded_rx #(
    parameter logic DBL_LOAD = 1'b0
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       EN,
    input  logic       SIN,
    input  logic       SVALID,
    input  logic       SOW,
    output logic [3:0] DATA,
    output logic       LOAD,
    output logic [2:0] SYN,
    output logic       ERR_COR,
    output logic       ERR_DBL,
    output logic       BUSY,
    output logic       DROP
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DEC   = 2'd2;

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] word_q, word_d;
    logic [3:0] data_q, data_d;
    logic [2:0] syn_q, syn_d;
    logic       cor_q, cor_d;
    logic       dbl_q, dbl_d;
    logic       load_q, load_d;
    logic       drop_q, drop_d;

    logic [2:0] syn;
    logic       q;
    logic       dbl;
    logic [7:0] fix;
    logic [3:0] nib;

    // word_q[i] holds codeword position i+1
    always_comb begin
        syn[0] = word_q[0] ^ word_q[2] ^ word_q[4] ^ word_q[6];
        syn[1] = word_q[1] ^ word_q[2] ^ word_q[5] ^ word_q[6];
        syn[2] = word_q[3] ^ word_q[4] ^ word_q[5] ^ word_q[6];
        q      = ^word_q;
        dbl    = (syn != 3'd0) && !q;
        fix    = word_q;
        if (syn != 3'd0 && q) begin
            fix[syn - 3'd1] = ~word_q[syn - 3'd1];
        end
        nib = {fix[6], fix[5], fix[4], fix[2]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        data_d  = data_q;
        syn_d   = syn_q;
        cor_d   = cor_q;
        dbl_d   = dbl_q;
        drop_d  = drop_q;
        load_d  = 1'b0;
        if (EN) begin
            case (state_q)
                S_IDLE: begin
                    if (SVALID && SOW) begin
                        word_d[0] = SIN;
                        cnt_d     = 3'd1;
                        state_d   = S_SHIFT;
                    end else if (SVALID) begin
                        drop_d = 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (SVALID && SOW) begin
                        word_d[0] = SIN;
                        cnt_d     = 3'd1;
                    end else if (SVALID) begin
                        word_d[cnt_q] = SIN;
                        cnt_d         = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_d = S_DEC;
                        end
                    end
                end
                S_DEC: begin
                    if (SVALID) begin
                        drop_d = 1'b1;
                    end
                    syn_d = syn;
                    cor_d = q;
                    dbl_d = dbl;
                    if (!dbl || DBL_LOAD) begin
                        data_d = nib;
                        load_d = 1'b1;
                    end
                    cnt_d   = 3'd0;
                    state_d = S_IDLE;
                end
                default: begin
                    cnt_d   = 3'd0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            word_q  <= 8'd0;
            data_q  <= 4'd0;
            syn_q   <= 3'd0;
            cor_q   <= 1'b0;
            dbl_q   <= 1'b0;
            load_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            data_q  <= data_d;
            syn_q   <= syn_d;
            cor_q   <= cor_d;
            dbl_q   <= dbl_d;
            load_q  <= load_d;
            drop_q  <= drop_d;
        end
    end

    assign DATA    = data_q;
    assign LOAD    = load_q;
    assign SYN     = syn_q;
    assign ERR_COR = cor_q;
    assign ERR_DBL = dbl_q;
    assign BUSY    = (state_q != S_IDLE);
    assign DROP    = drop_q;

endmodule

// File: tb/tb_hamming_secded_rx.sv
// Bench for hamming_secded_rx: vector table, random words vs a
// syndrome-as-index-XOR model, and framing/enable/reset sequences.
module tb_hamming_secded_rx;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic       EN = 1'b1;
    logic       SIN = 1'b0;
    logic       SVALID = 1'b0;
    logic       SOW = 1'b0;

    logic [3:0] d0, d1;
    logic [2:0] s0, s1;
    logic       l0, l1, c0, c1, b0, b1, k0, k1, r0, r1;

    int checks = 0;
    int errors = 0;
    int lc = 0;

    hamming_secded_rx #(.DBL_LOAD(1'b0)) u0 (
        .CLK(CLK), .CLR(CLR), .EN(EN), .SIN(SIN), .SVALID(SVALID),
        .SOW(SOW), .DATA(d0), .LOAD(l0), .SYN(s0), .ERR_COR(c0),
        .ERR_DBL(b0), .BUSY(k0), .DROP(r0)
    );

    hamming_secded_rx #(.DBL_LOAD(1'b1)) u1 (
        .CLK(CLK), .CLR(CLR), .EN(EN), .SIN(SIN), .SVALID(SVALID),
        .SOW(SOW), .DATA(d1), .LOAD(l1), .SYN(s1), .ERR_COR(c1),
        .ERR_DBL(b1), .BUSY(k1), .DROP(r1)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (l0 === 1'b1) lc++;

    typedef struct {
        logic [7:0] w;
        logic [3:0] d0;
        logic       l0;
        logic [3:0] d1;
        logic       l1;
        logic [2:0] syn;
        logic       cor;
        logic       dbl;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic put(input logic sv, input logic sw, input logic b);
        SVALID = sv;
        SOW    = sw;
        SIN    = b;
        tick();
    endtask

    // Ends just after the edge that samples the 8th bit
    task automatic send_bits(input logic [7:0] w);
        for (int i = 0; i < 8; i++) put(1'b1, i == 0, w[i]);
        SVALID = 1'b0;
        SOW    = 1'b0;
        chk("busy_in_decode", 8'(k0), 8'd1);
        chk("load_early", 8'(l0), 8'd0);
    endtask

    task automatic send_word(input logic [7:0] w);
        send_bits(w);
        tick();
    endtask

    // Called just after edge k+1
    task automatic check_out(input logic [3:0] ed0, input logic el0,
                             input logic [3:0] ed1, input logic el1,
                             input logic [2:0] es, input logic ec,
                             input logic eb);
        chk("data0", 8'(d0), 8'(ed0));
        chk("load0", 8'(l0), 8'(el0));
        chk("data1", 8'(d1), 8'(ed1));
        chk("load1", 8'(l1), 8'(el1));
        chk("syn0", 8'(s0), 8'(es));
        chk("cor0", 8'(c0), 8'(ec));
        chk("dbl0", 8'(b0), 8'(eb));
        chk("syn1", 8'(s1), 8'(es));
        chk("cor1", 8'(c1), 8'(ec));
        chk("dbl1", 8'(b1), 8'(eb));
        chk("busy_after", 8'(k0), 8'd0);
        tick();
        chk("load0_fall", 8'(l0), 8'd0);
        chk("load1_fall", 8'(l1), 8'd0);
    endtask

    // Parity bits chosen so the XOR of indices of set bits is zero
    function automatic logic [7:0] enc(input logic [3:0] d);
        logic [7:0] w;
        logic [2:0] s;
        w = 8'd0;
        w[2] = d[0];
        w[4] = d[1];
        w[5] = d[2];
        w[6] = d[3];
        s = 3'd0;
        for (int i = 1; i <= 7; i++) if (w[i-1]) s ^= 3'(i);
        w[0] = s[0];
        w[1] = s[1];
        w[3] = s[2];
        w[7] = ^w[6:0];
        return w;
    endfunction

    task automatic model(input logic [7:0] w, output logic [3:0] d,
                         output logic [2:0] s, output logic cor,
                         output logic dbl);
        logic [7:0] c;
        int par;
        s   = 3'd0;
        par = 0;
        for (int i = 1; i <= 7; i++) if (w[i-1]) s ^= 3'(i);
        for (int i = 0; i < 8; i++) par = par ^ int'(w[i]);
        c = w;
        if (s != 3'd0 && par == 1) c[int'(s)-1] = ~c[int'(s)-1];
        d   = {c[6], c[5], c[4], c[2]};
        cor = (par == 1);
        dbl = (s != 3'd0) && (par == 0);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_data"}, 8'(d0), 8'd0);
        chk({nm, "_load"}, 8'(l0), 8'd0);
        chk({nm, "_syn"}, 8'(s0), 8'd0);
        chk({nm, "_cor"}, 8'(c0), 8'd0);
        chk({nm, "_dbl"}, 8'(b0), 8'd0);
        chk({nm, "_busy"}, 8'(k0), 8'd0);
        chk({nm, "_drop"}, 8'(r0), 8'd0);
        chk({nm, "_data1"}, 8'(d1), 8'd0);
    endtask

    initial begin
        logic [7:0] w, wb;
        logic [3:0] md, m0, m1;
        logic [2:0] ms;
        logic       mc, mb;
        int         lcs, p1, p2, nf;

        tbl[0] = '{8'h55, 4'hB, 1'b1, 4'hB, 1'b1, 3'd0, 1'b0, 1'b0};
        for (int p = 1; p <= 7; p++)
            tbl[p] = '{8'h55 ^ (8'h01 << (p - 1)), 4'hB, 1'b1, 4'hB,
                       1'b1, 3'(p), 1'b1, 1'b0};
        tbl[8]  = '{8'hD5, 4'hB, 1'b1, 4'hB, 1'b1, 3'd0, 1'b1, 1'b0};
        tbl[9]  = '{8'h00, 4'h0, 1'b1, 4'h0, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[10] = '{8'h71, 4'h0, 1'b0, 4'hE, 1'b1, 3'd5, 1'b0, 1'b1};

        #2;
        chk_reset("reset");
        tick();
        tick();
        CLR = 1'b0;

        for (int i = 0; i < 11; i++) begin
            send_word(tbl[i].w);
            check_out(tbl[i].d0, tbl[i].l0, tbl[i].d1, tbl[i].l1,
                      tbl[i].syn, tbl[i].cor, tbl[i].dbl);
        end

        m0 = 4'h0;
        m1 = 4'hE;
        for (int n = 0; n < 40; n++) begin
            w  = enc(4'($urandom_range(0, 15)));
            nf = $urandom_range(0, 2);
            p1 = $urandom_range(0, 7);
            p2 = (p1 + 1 + $urandom_range(0, 6)) % 8;
            if (nf >= 1) w[p1] = ~w[p1];
            if (nf == 2) w[p2] = ~w[p2];
            model(w, md, ms, mc, mb);
            if (!mb) m0 = md;
            m1 = md;
            send_word(w);
            check_out(m0, !mb, m1, 1'b1, ms, mc, mb);
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end

        // Restart mid-word: only the second word loads
        lcs = lc;
        w = enc(4'h3);
        for (int i = 0; i < 4; i++) put(1'b1, i == 0, w[i]);
        send_word(enc(4'h6));
        check_out(4'h6, 1'b1, 4'h6, 1'b1, 3'd0, 1'b0, 1'b0);
        chk("abort_one_load", 8'(lc - lcs), 8'd1);
        chk("abort_no_drop", 8'(r0), 8'd0);

        put(1'b1, 1'b0, 1'b1);
        chk("idle_drop", 8'(r0), 8'd1);
        chk("idle_drop_busy", 8'(k0), 8'd0);

        CLR = 1'b1;
        #1;
        CLR = 1'b0;
        chk("clr_drop", 8'(r0), 8'd0);

        // SOW on k+1 is dropped, on k+2 accepted
        w  = enc(4'h9);
        wb = enc(4'h4);
        send_bits(w);
        put(1'b1, 1'b1, wb[0]);
        chk("b2b_load", 8'(l0), 8'd1);
        chk("b2b_data", 8'(d0), 8'h9);
        chk("b2b_drop", 8'(r0), 8'd1);
        chk("b2b_busy", 8'(k0), 8'd0);
        send_word(wb);
        check_out(4'h4, 1'b1, 4'h4, 1'b1, 3'd0, 1'b0, 1'b0);

        // Enable gaps mid-word and during DECODE
        w = enc(4'hA);
        for (int i = 0; i < 3; i++) put(1'b1, i == 0, w[i]);
        EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(1'b1, i == 1, ~w[3]);
            chk("en_mid_busy", 8'(k0), 8'd1);
        end
        EN = 1'b1;
        for (int i = 3; i < 8; i++) put(1'b1, 1'b0, w[i]);
        SVALID = 1'b0;
        EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en_dec_load", 8'(l0), 8'd0);
            chk("en_dec_busy", 8'(k0), 8'd1);
        end
        EN = 1'b1;
        tick();
        check_out(4'hA, 1'b1, 4'hA, 1'b1, 3'd0, 1'b0, 1'b0);

        // Async clear mid-word after a corrected word
        send_word(enc(4'hF) ^ 8'h04);
        check_out(4'hF, 1'b1, 4'hF, 1'b1, 3'd3, 1'b1, 1'b0);
        w = enc(4'hC);
        for (int i = 0; i < 5; i++) put(1'b1, i == 0, w[i]);
        SVALID = 1'b0;
        CLR = 1'b1;
        #1;
        chk_reset("clr_mid");
        #1;
        CLR = 1'b0;
        send_word(enc(4'h5));
        check_out(4'h5, 1'b1, 4'h5, 1'b1, 3'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
